// File: rtl/bcd_updown_counter_n.sv
// Multi-digit cascaded BCD up/down counter with count enable, checked parallel load,
// and a combinational carry/borrow output for chaining instances.
module bcd_updown_counter_n #(
    parameter int unsigned                DIGITS  = 4,
    parameter logic [4*DIGITS-1:0]        RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  co,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]    load_val;
    logic            load_bad;
    logic [W-1:0]    q_step;
    logic [DIGITS:0] below_nine;
    logic [DIGITS:0] below_zero;

    // below_nine[i]: every digit under position i is 9, so digit i steps when counting up.
    always_comb begin
        below_nine    = '0;
        below_zero    = '0;
        below_nine[0] = 1'b1;
        below_zero[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            below_nine[i+1] = below_nine[i] & (q[4*i +: 4] == 4'd9);
            below_zero[i+1] = below_zero[i] & (q[4*i +: 4] == 4'd0);
        end
    end

    // Illegal nibbles load as 0 and raise the error flag.
    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_val[4*i +: 4] = d[4*i +: 4];
            end
        end
    end

    always_comb begin
        q_step = q;
        for (int i = 0; i < DIGITS; i++) begin
            if (up) begin
                if (below_nine[i]) begin
                    q_step[4*i +: 4] = (q[4*i +: 4] == 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1;
                end
            end else begin
                if (below_zero[i]) begin
                    q_step[4*i +: 4] = (q[4*i +: 4] == 4'd0) ? 4'd9 : q[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q        <= RST_VAL;
            load_err <= 1'b0;
        end else if (load) begin
            q        <= load_val;
            load_err <= load_bad;
        end else begin
            load_err <= 1'b0;
            if (en) begin
                q <= q_step;
            end
        end
    end

    assign co = en & ~load & rst & (up ? below_nine[DIGITS] : below_zero[DIGITS]);

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench: driver pushes expected outputs from an integer-valued model,
// monitor pops and compares every cycle.
module tb_bcd_updown_counter_n;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int unsigned MODV   = 10000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         co;
    logic         load_err;

    bcd_updown_counter_n #(
        .DIGITS  (DIGITS),
        .RST_VAL ('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .d        (d),
        .q        (q),
        .co       (co),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         co;
        logic         err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned model_val = 0;
    bit          model_err = 1'b0;
    bit          model_known = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal value of a load word with illegal digits treated as zero.
    function automatic int unsigned load_value(input logic [W-1:0] dv, output bit bad);
        int unsigned v;
        int unsigned scale;
        int unsigned nib;
        v = 0;
        scale = 1;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(dv[4*i +: 4]);
            if (nib > 9) bad = 1'b1;
            else v = v + nib * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input logic [W-1:0] dv);
        exp_t        x;
        bit          bad;
        int unsigned lv;
        @(negedge clk);
        #1;
        rst  = r;
        en   = e;
        up   = u;
        load = l;
        d    = dv;
        if (model_known) begin
            x.q   = to_bcd(model_val);
            x.err = model_err;
            x.co  = e & ~l & r & (u ? (model_val == MODV - 1) : (model_val == 0));
            sb.push_back(x);
        end
        if (!r) begin
            model_val   = 0;
            model_err   = 1'b0;
            model_known = 1'b1;
        end else if (l) begin
            lv        = load_value(dv, bad);
            model_val = lv;
            model_err = bad;
        end else begin
            model_err = 1'b0;
            if (e) model_val = u ? (model_val + 1) % MODV : (model_val + MODV - 1) % MODV;
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (q !== x.q) begin
                    failures++;
                    $display("FAIL q: got %h expected %h at %0t", q, x.q, $time);
                end
                checks++;
                if (co !== x.co) begin
                    failures++;
                    $display("FAIL co: got %b expected %b (q=%h) at %0t", co, x.co, q, $time);
                end
                checks++;
                if (load_err !== x.err) begin
                    failures++;
                    $display("FAIL load_err: got %b expected %b at %0t", load_err, x.err, $time);
                end
            end
        end
    end

    initial begin : driver
        logic [W-1:0] rd;
        int           wait_cnt;
        // Reset held against load/en
        step(0, 1, 1, 1, 16'h1234);
        step(0, 1, 1, 1, 16'h1234);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 0, 1, 0, 16'h0000);
        // Up ripple and wrap
        step(1, 0, 1, 1, 16'h0999);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 1, 1, 1, 16'h9998);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 0, 1, 0, 16'h0000);
        // Down ripple and wrap
        step(1, 0, 0, 1, 16'h1000);
        step(1, 1, 0, 0, 16'h0000);
        step(1, 1, 0, 1, 16'h0001);
        step(1, 1, 0, 0, 16'h0000);
        step(1, 1, 0, 0, 16'h0000);
        step(1, 0, 0, 0, 16'h0000);
        // Illegal load
        step(1, 0, 1, 1, 16'h3A7F);
        step(1, 0, 1, 0, 16'h0000);
        step(1, 0, 1, 0, 16'h0000);
        // Load priority, hold, direction toggle
        step(1, 1, 1, 1, 16'h0500);
        for (int i = 0; i < 5; i++) step(1, 0, i[0], 0, 16'h0000);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 1, 0, 0, 16'h0000);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 0, 1, 0, 16'h0000);
        // Reset mid-count
        step(1, 0, 1, 1, 16'h0098);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 1, 1, 0, 16'h0000);
        step(0, 1, 1, 0, 16'h0000);
        step(1, 1, 1, 0, 16'h0000);
        step(1, 0, 1, 0, 16'h0000);
        // Randomised traffic, biased toward the wrap points
        for (int n = 0; n < 600; n++) begin
            rd = W'($urandom);
            case ($urandom_range(0, 3))
                0: rd = 16'h9999 - W'($urandom_range(0, 2));
                1: rd = W'($urandom_range(0, 2));
                2: for (int i = 0; i < DIGITS; i++) rd[4*i +: 4] = 4'($urandom_range(0, 9));
                default: ;
            endcase
            step($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 75,
                 1'($urandom), $urandom_range(0, 99) < 8, rd);
        end
        step(1, 0, 1, 0, 16'h0000);
        step(1, 0, 1, 0, 16'h0000);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
